// File: rtl/shift_sequencer.sv
// Word-to-serial sequencer driving a downstream shift register (clear, shift, done).
// Build option: define SHIFT_SEQ_MSB_FIRST_EN for MSB-first order; default is LSB-first.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    input  logic             Abort,
    output logic             ClearReg,
    output logic             ShiftEn,
    output logic             ShiftIn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] BitCount
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IW-1:0]    idx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt only survives while shifting; it reads WIDTH in DONE
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        cnt_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (InValid) begin
                    state_nxt = CLEAR;
                    word_nxt  = InData;
                end
            end
            CLEAR: state_nxt = Abort ? FLUSH : SHIFT;
            SHIFT: begin
                if (Abort) begin
                    state_nxt = FLUSH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SHIFT_SEQ_MSB_FIRST_EN
    assign idx = IW'(WIDTH - 1) - cnt[IW-1:0];
`else
    assign idx = cnt[IW-1:0];
`endif

    assign InReady  = (state == IDLE);
    assign Busy     = (state != IDLE);
    assign ClearReg = (state == CLEAR) || (state == FLUSH);
    assign ShiftEn  = (state == SHIFT);
    assign ShiftIn  = (state == SHIFT) && word[idx];
    assign Done     = (state == DONE);
    assign BitCount = cnt;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, bits per word serialised into the downstream shift register; legal range 2..16.
REQ-002 Parameter: CNT_W, default 5, width of BitCount; SHALL be wide enough to hold WIDTH.
REQ-003 Port: Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: InValid  input  1  upstream word valid.
REQ-006 Port: InData  input  WIDTH  upstream parallel word.
REQ-007 Port: InReady  output  1  sequencer can accept a word.
REQ-008 Port: Abort  input  1  cancel the current word.
REQ-009 Port: ClearReg  output  1  one-cycle clear strobe to the shift register's Reset.
REQ-010 Port: ShiftEn  output  1  high during every cycle a data bit is presented.
REQ-011 Port: ShiftIn  output  1  serial bit to the shift register's ShiftIn.
REQ-012 Port: Busy  output  1  high in any state other than IDLE.
REQ-013 Port: Done  output  1  one-cycle pulse when a word has completed.
REQ-014 Port: BitCount  output  CNT_W  number of bits of the current word already shifted.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE and FLUSH; all outputs are registered or decoded from the state only, with no combinational path from inputs.
REQ-016 In IDLE, InReady=1; InValid=1 at an edge latches InData and moves to CLEAR; otherwise the FSM stays in IDLE.
REQ-017 CLEAR lasts exactly one cycle with ClearReg=1 and ShiftEn=0, then moves to SHIFT.
REQ-018 SHIFT lasts exactly WIDTH cycles with ShiftEn=1, presenting one latched bit per cycle on ShiftIn.
REQ-019 BitCount SHALL be 0 in the first SHIFT cycle and increment by 1 per SHIFT cycle.
REQ-020 BitCount SHALL read WIDTH in DONE and 0 in IDLE.
REQ-021 DONE lasts one cycle with Done=1, then the FSM returns to IDLE.
REQ-022 Latency: for a word accepted at edge k, ClearReg is high in cycle k+1, ShiftEn is high in cycles k+2..k+1+WIDTH, Done is high in cycle k+2+WIDTH, and InReady is high again in cycle k+3+WIDTH.
REQ-023 Outside SHIFT, ShiftIn=0 and ShiftEn=0.
REQ-024 InReady=0 in every state except IDLE.
REQ-025 InValid outside IDLE SHALL be ignored, and the latched word SHALL NOT change.
REQ-026 Abort=1 in CLEAR or SHIFT SHALL move the FSM to FLUSH at the next edge, suppressing any remaining ShiftEn cycles and Done for that word.
REQ-027 FLUSH lasts one cycle with ClearReg=1 and BitCount=0, then moves to IDLE.
REQ-028 Abort in IDLE, DONE or FLUSH SHALL be ignored; Abort together with InValid in IDLE SHALL still accept the word.
REQ-029 Abort in the last SHIFT cycle SHALL take priority over the transition to DONE: no Done pulse.
REQ-030 Back-to-back words SHALL be separated by exactly one IDLE cycle; throughput is one word per WIDTH+3 cycles.

Reset
REQ-031 Reset=1 at an edge SHALL force IDLE, overriding Abort and InValid.
REQ-032 Reset values: InReady=1, ClearReg=0, ShiftEn=0, ShiftIn=0, Busy=0, Done=0, BitCount=0, latched word=0.
REQ-033 Reset asserted mid-SHIFT SHALL drop ShiftEn in the following cycle, with no Done and no FLUSH cycle.

Configuration
REQ-034 Macro SHIFT_SEQ_MSB_FIRST_EN defined: bits are presented MSB first (InData[WIDTH-1] first).
REQ-035 Macro SHIFT_SEQ_MSB_FIRST_EN undefined: bits are presented LSB first (InData[0] first); all timing is identical in both builds.

Verification
REQ-036 Reset held for 2 cycles, then released -> InReady=1, Busy=0, Done=0, BitCount=0, ShiftEn=0.
REQ-037 WIDTH=4, InData=4'b1100, InValid pulsed one cycle -> ClearReg for 1 cycle, then ShiftIn 1,1,0,0 (MSB_FIRST_EN) or 0,0,1,1 (undefined) under ShiftEn over 4 cycles, then Done for 1 cycle; downstream Q=4'b1100 (MSB build).
REQ-038 InValid held high with words 4'b1010 then 4'b0110 -> second word accepted exactly 1 IDLE cycle after the first Done; the second word is unaffected by InValid during busy.
REQ-039 Abort asserted on the 2nd SHIFT cycle -> FLUSH with ClearReg=1 next cycle, then IDLE; no Done, and ShiftEn high for exactly 2 cycles.
REQ-040 Reset asserted on the 3rd SHIFT cycle -> next cycle all outputs at reset values, no Done, no ClearReg.
REQ-041 Abort and InValid together in IDLE with InData=4'b0001 -> word accepted; full 4-bit sequence and Done produced.
